lcd_write_controller: RTL and testbench

LCD_WRITE_CONTROLLER -- requirements
Module: lcd_write_controller

---
 rtl/lcd_write_controller_pkg.sv | 63 ++++++
 rtl/lcd_write_controller_if.sv | 25 ++
 rtl/lcd_write_controller_nibble_tx.sv | 69 ++++++
 rtl/lcd_write_controller.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_write_controller.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_write_controller_pkg.sv
// Shared definitions for the LCD write controller: default HD44780 timing
// constants, init/config command values, FSM state types and request payload.
package lcd_write_controller_pkg;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  // Default timing in clocks at 50 MHz
  localparam int unsigned T_PWR_DEF   = 750000;
  localparam int unsigned T_E_DEF     = 12;
  localparam int unsigned T_GAP_DEF   = 50;
  localparam int unsigned T_CMD_DEF   = 2000;
  localparam int unsigned T_CLR_DEF   = 82000;
  localparam int unsigned T_INIT1_DEF = 205000;
  localparam int unsigned T_INIT2_DEF = 5000;

  // Power-up nibbles and configuration bytes
  localparam logic [NIB_W-1:0]  INIT_NIB_8BIT  = 4'h3;
  localparam logic [NIB_W-1:0]  INIT_NIB_4BIT  = 4'h2;
  localparam logic [BYTE_W-1:0] CMD_FUNC_SET   = 8'h28;
  localparam logic [BYTE_W-1:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [BYTE_W-1:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [BYTE_W-1:0] CMD_CLEAR      = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_HOME       = 8'h02;

  localparam logic [1:0] INIT_LAST = 2'd3;
  localparam logic [1:0] CFG_LAST  = 2'd3;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, CFG, IDLE, SEND_HI, GAP, SEND_LO, POST_WAIT
  } lcd_state_e;

  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_HIGH} tx_state_e;

  // Latched write request
  typedef struct packed {
    logic              rs;
    logic [BYTE_W-1:0] data;
  } lcd_req_t;

  function automatic logic [NIB_W-1:0] init_nibble(input logic [1:0] idx);
    case (idx)
      2'd3:    init_nibble = INIT_NIB_4BIT;
      default: init_nibble = INIT_NIB_8BIT;
    endcase
  endfunction

  function automatic logic [BYTE_W-1:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_byte = CMD_FUNC_SET;
      2'd1:    cfg_byte = CMD_ENTRY_MODE;
      2'd2:    cfg_byte = CMD_DISP_ON;
      default: cfg_byte = CMD_CLEAR;
    endcase
  endfunction

  // Clear and home need the long post-write wait
  function automatic logic needs_long_wait(input lcd_req_t req);
    needs_long_wait = !req.rs && ((req.data == CMD_CLEAR) || (req.data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_write_controller_if.sv
// CPU request / LCD pin bundle for the LCD write controller.
//   master: drives iValid/iRS/iData, observes oReady and the LCD pins
//   slave : the controller
interface lcd_write_controller_if;
  import lcd_write_controller_pkg::*;

  logic              iValid;
  logic              iRS;
  logic [BYTE_W-1:0] iData;
  logic              oReady;
  logic              oLCD_E;
  logic              oLCD_RS;
  logic              oLCD_RW;
  logic [NIB_W-1:0]  oLCD_Data;

  modport master (
    output iValid, iRS, iData,
    input  oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data
  );

  modport slave (
    input  iValid, iRS, iData,
    output oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data
  );
endinterface

// File: rtl/lcd_write_controller_nibble_tx.sv
// lcd_nibble_tx: drives one nibble onto the LCD bus.
//   Cycle 0 after i_start: RS/data valid, E low; cycles 1..T_E: E high.
//   RS/data are held until the next i_start.
// Ports: i_clk, i_rst (sync, active high), i_start, i_nibble, i_rs,
//        o_lcd_e, o_lcd_rs, o_lcd_data, o_done_c (last E-high cycle).
module lcd_nibble_tx
  import lcd_write_controller_pkg::*;
#(
  parameter int unsigned T_E = T_E_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NIB_W-1:0] i_nibble,
  input  logic             i_rs,
  output logic             o_lcd_e,
  output logic             o_lcd_rs,
  output logic [NIB_W-1:0] o_lcd_data,
  output logic             o_done_c
);

  tx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_e;
  logic             r_rs;
  logic [NIB_W-1:0] r_data;

  assign o_lcd_e    = r_e;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_data = r_data;
  // Asserted during the final E-high cycle so the caller can chain its wait
  assign o_done_c   = (r_state == TX_HIGH) && (r_cnt <= CNT_W'(1));

  // Setup / strobe sequencer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (i_start) begin
            r_data  <= i_nibble;
            r_rs    <= i_rs;
            r_state <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          r_e     <= 1'b1;
          r_cnt   <= CNT_W'(T_E);
          r_state <= TX_HIGH;
        end
        TX_HIGH: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_e     <= 1'b0;
            r_state <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_write_controller.sv
// lcd_write_controller: HD44780 4-bit write-only controller. Runs the
// power-up nibble sequence and configuration bytes, then accepts one byte
// write at a time from the CPU and sends it as two strobed nibbles.
// Ports: Clock, Reset (sync, active high), bus (slave modport):
//   iValid/iRS/iData request, oReady idle flag, oLCD_E/RS/RW/Data pins.
module lcd_write_controller
  import lcd_write_controller_pkg::*;
#(
  parameter int unsigned T_PWR   = T_PWR_DEF,
  parameter int unsigned T_E     = T_E_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF,
  parameter int unsigned T_CMD   = T_CMD_DEF,
  parameter int unsigned T_CLR   = T_CLR_DEF,
  parameter int unsigned T_INIT1 = T_INIT1_DEF,
  parameter int unsigned T_INIT2 = T_INIT2_DEF
) (
  input logic                   Clock,
  input logic                   Reset,
  lcd_write_controller_if.slave bus
);

  lcd_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_step;
  logic [1:0]        r_cfg_idx;
  logic              r_cfg_mode;
  lcd_req_t          r_req;
  logic              r_ready;

  logic              w_cnt_last;
  logic              w_accept;
  logic              w_start;
  logic [NIB_W-1:0]  w_nib;
  logic              w_rs;
  logic              w_tx_done;
  logic              w_lcd_e;
  logic              w_lcd_rs;
  logic [NIB_W-1:0]  w_lcd_data;
  logic [BYTE_W-1:0] w_cfg_byte;
  logic [CNT_W-1:0]  w_init_wait;
  logic [CNT_W-1:0]  w_post_wait;

  // Wait counters hold N clocks: loaded with N, leave when reaching 1 -> 0
  assign w_cnt_last  = (r_cnt <= CNT_W'(1));
  assign w_accept    = r_ready && bus.iValid;
  assign w_cfg_byte  = cfg_byte(r_cfg_idx);
  assign w_post_wait = needs_long_wait(r_req) ? CNT_W'(T_CLR) : CNT_W'(T_CMD);

  always_comb begin
    w_init_wait = CNT_W'(T_CMD);
    case (r_step)
      2'd0:    w_init_wait = CNT_W'(T_INIT1);
      2'd1:    w_init_wait = CNT_W'(T_INIT2);
      default: w_init_wait = CNT_W'(T_CMD);
    endcase
  end

  // Nibble start strobe: fires on the edge that leaves the previous phase so
  // the setup cycle follows immediately.
  always_comb begin
    w_start = 1'b0;
    w_nib   = '0;
    w_rs    = 1'b0;
    case (r_state)
      PWR_WAIT: begin
        if (w_cnt_last) begin
          w_start = 1'b1;
          w_nib   = init_nibble(2'd0);
        end
      end
      INIT_WAIT: begin
        if (w_cnt_last && (r_step != INIT_LAST)) begin
          w_start = 1'b1;
          w_nib   = init_nibble(r_step + 2'd1);
        end
      end
      CFG: begin
        w_start = 1'b1;
        w_nib   = w_cfg_byte[7:4];
      end
      IDLE: begin
        if (w_accept) begin
          w_start = 1'b1;
          w_nib   = bus.iData[7:4];
          w_rs    = bus.iRS;
        end
      end
      GAP: begin
        if (w_cnt_last) begin
          w_start = 1'b1;
          w_nib   = r_req.data[3:0];
          w_rs    = r_req.rs;
        end
      end
      default: ;
    endcase
    if (Reset) w_start = 1'b0;
  end

  lcd_nibble_tx #(.T_E(T_E)) u_tx (
    .i_clk      (Clock),
    .i_rst      (Reset),
    .i_start    (w_start),
    .i_nibble   (w_nib),
    .i_rs       (w_rs),
    .o_lcd_e    (w_lcd_e),
    .o_lcd_rs   (w_lcd_rs),
    .o_lcd_data (w_lcd_data),
    .o_done_c   (w_tx_done)
  );

  assign bus.oReady    = r_ready;
  assign bus.oLCD_E    = w_lcd_e;
  assign bus.oLCD_RS   = w_lcd_rs;
  assign bus.oLCD_RW   = 1'b0;
  assign bus.oLCD_Data = w_lcd_data;

  // Main sequencer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= PWR_WAIT;
      r_cnt      <= CNT_W'(T_PWR);
      r_step     <= 2'd0;
      r_cfg_idx  <= 2'd0;
      r_cfg_mode <= 1'b0;
      r_req      <= '0;
      r_ready    <= 1'b0;
    end else begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      case (r_state)
        PWR_WAIT: begin
          if (w_cnt_last) begin
            r_step  <= 2'd0;
            r_state <= INIT_NIB;
          end
        end
        INIT_NIB: begin
          if (w_tx_done) begin
            r_cnt   <= w_init_wait;
            r_state <= INIT_WAIT;
          end
        end
        INIT_WAIT: begin
          if (w_cnt_last) begin
            if (r_step == INIT_LAST) begin
              r_cfg_idx  <= 2'd0;
              r_cfg_mode <= 1'b1;
              r_state    <= CFG;
            end else begin
              r_step  <= r_step + 2'd1;
              r_state <= INIT_NIB;
            end
          end
        end
        CFG: begin
          r_req.rs   <= 1'b0;
          r_req.data <= w_cfg_byte;
          r_state    <= SEND_HI;
        end
        IDLE: begin
          if (w_accept) begin
            r_req.rs   <= bus.iRS;
            r_req.data <= bus.iData;
            r_ready    <= 1'b0;
            r_state    <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (w_tx_done) begin
            r_cnt   <= CNT_W'(T_GAP);
            r_state <= GAP;
          end
        end
        GAP: begin
          if (w_cnt_last) r_state <= SEND_LO;
        end
        SEND_LO: begin
          if (w_tx_done) begin
            r_cnt   <= w_post_wait;
            r_state <= POST_WAIT;
          end
        end
        POST_WAIT: begin
          if (w_cnt_last) begin
            if (r_cfg_mode && (r_cfg_idx != CFG_LAST)) begin
              r_cfg_idx <= r_cfg_idx + 2'd1;
              r_state   <= CFG;
            end else begin
              r_cfg_mode <= 1'b0;
              r_ready    <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_controller.sv
// Directed bench for lcd_write_controller with reduced timing constants.
// A negedge monitor logs every E pulse (start cycle, nibble, RS, width) and
// checks RS/data stability; the main sequence compares against hand tables.
module tb_lcd_write_controller;

  localparam int unsigned P_PWR = 20, P_INIT1 = 10, P_INIT2 = 5, P_CMD = 8;
  localparam int unsigned P_CLR = 30, P_E = 3, P_GAP = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  lcd_write_controller_if bus ();

  lcd_write_controller #(
    .T_PWR(P_PWR), .T_E(P_E), .T_GAP(P_GAP), .T_CMD(P_CMD),
    .T_CLR(P_CLR), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // E-pulse log, times relative to the first cycle after reset release
  int   q_t[$];
  int   q_d[$];
  int   q_rs[$];
  int   q_w[$];
  logic e_prev = 1'b0;
  logic [3:0] cur_d = '0;
  logic cur_rs = 1'b0;
  int   rise_t = 0;

  always @(negedge Clock) begin
    if (Reset) begin
      e_prev = 1'b0;
    end else begin
      if (bus.oLCD_E && !e_prev) begin
        rise_t = cyc - base;
        cur_d  = bus.oLCD_Data;
        cur_rs = bus.oLCD_RS;
        q_t.push_back(rise_t);
        q_d.push_back(int'(bus.oLCD_Data));
        q_rs.push_back(int'(bus.oLCD_RS));
        chk("rw_low", 32'(bus.oLCD_RW), 0);
      end else if (bus.oLCD_E) begin
        chk("hold_e_high", 32'({bus.oLCD_RS, bus.oLCD_Data}), 32'({cur_rs, cur_d}));
      end else if (e_prev) begin
        q_w.push_back(cyc - base - rise_t);
        chk("hold_after_fall", 32'({bus.oLCD_RS, bus.oLCD_Data}), 32'({cur_rs, cur_d}));
      end
      e_prev = bus.oLCD_E;
    end
  end

  task automatic clear_log();
    q_t.delete(); q_d.delete(); q_rs.delete(); q_w.delete();
  endtask

  task automatic wait_ready(input int limit, output int t);
    bit seen;
    seen = 1'b0;
    t = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge Clock);
      if (bus.oReady === 1'b1) begin
        seen = 1'b1;
        t = cyc - base;
      end
    end
    if (!seen) chk("ready_timeout", 32'(bus.oReady), 1);
  endtask

  task automatic check_pulse(input string tag, input int idx, input int a,
                             input int et, input int ed, input int ers);
    if (idx < q_t.size() && idx < q_w.size()) begin
      chk({tag, "_time"},  q_t[idx] - a, et);
      chk({tag, "_data"},  q_d[idx], ed);
      chk({tag, "_rs"},    q_rs[idx], ers);
      chk({tag, "_width"}, q_w[idx], P_E);
    end else begin
      chk({tag, "_missing"}, q_w.size(), idx + 1);
    end
  endtask

  // Hand-derived init schedule: PWR 0..19, nibble setup 20, E 21..23, waits
  // 10/5/8/8, then each config byte = 1 CFG cycle + 12 strobe cycles + wait.
  int init_t [12] = '{21, 35, 44, 56, 69, 77, 90, 98, 111, 119, 132, 140};
  int init_d [12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};

  task automatic check_init(input string tag);
    int t;
    wait_ready(400, t);
    chk({tag, "_ready_cycle"}, t, 173);
    chk({tag, "_pulse_count"}, q_t.size(), 12);
    for (int i = 0; i < 12; i++) check_pulse($sformatf("%s_p%0d", tag, i), i, 0, init_t[i], init_d[i], 0);
  endtask

  initial begin
    int a;
    int t;
    bit ok;
    bus.iValid = 1'b0;
    bus.iRS    = 1'b0;
    bus.iData  = '0;

    // Reset state
    repeat (3) @(negedge Clock);
    chk("rst_e",     32'(bus.oLCD_E), 0);
    chk("rst_rs",    32'(bus.oLCD_RS), 0);
    chk("rst_rw",    32'(bus.oLCD_RW), 0);
    chk("rst_data",  32'(bus.oLCD_Data), 0);
    chk("rst_ready", 32'(bus.oReady), 0);
    Reset = 1'b0;
    base  = cyc;
    clear_log();

    // Power-up sequence
    check_init("init");

    // Data write 'H'
    clear_log();
    @(negedge Clock);
    a = cyc - base;
    bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h48;
    @(negedge Clock);
    bus.iValid = 1'b0; bus.iData = 8'h00;
    chk("H_busy", 32'(bus.oReady), 0);
    wait_ready(100, t);
    chk("H_ready_cycle", t - a, 21);
    chk("H_pulse_count", q_t.size(), 2);
    check_pulse("H_hi", 0, a, 2, 4, 1);
    check_pulse("H_lo", 1, a, 10, 8, 1);

    // Clear command uses the long post-write wait
    clear_log();
    @(negedge Clock);
    a = cyc - base;
    bus.iValid = 1'b1; bus.iRS = 1'b0; bus.iData = 8'h01;
    @(negedge Clock);
    bus.iValid = 1'b0;
    wait_ready(100, t);
    chk("CLR_ready_cycle", t - a, 43);
    check_pulse("CLR_hi", 0, a, 2, 0, 0);
    check_pulse("CLR_lo", 1, a, 10, 1, 0);

    // Request while busy is dropped
    clear_log();
    @(negedge Clock);
    a = cyc - base;
    bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h48;
    @(negedge Clock);
    bus.iValid = 1'b0;
    repeat (2) @(negedge Clock);
    bus.iValid = 1'b1; bus.iData = 8'h4F;
    @(negedge Clock);
    bus.iValid = 1'b0;
    wait_ready(100, t);
    chk("BUSY_ready_cycle", t - a, 21);
    repeat (5) @(negedge Clock);
    chk("BUSY_pulse_count", q_t.size(), 2);
    chk("BUSY_still_ready", 32'(bus.oReady), 1);
    check_pulse("BUSY_hi", 0, a, 2, 4, 1);
    check_pulse("BUSY_lo", 1, a, 10, 8, 1);

    // Back-to-back with iValid held: 'H' then 'O' at byte time + 1 spacing
    clear_log();
    @(negedge Clock);
    a = cyc - base;
    bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h48;
    @(negedge Clock);
    bus.iData = 8'h4F;
    wait_ready(100, t);
    chk("B2B_first_ready", t - a, 21);
    @(negedge Clock);
    chk("B2B_second_accepted", 32'(bus.oReady), 0);
    bus.iValid = 1'b0;
    wait_ready(100, t);
    chk("B2B_second_ready", t - a, 42);
    chk("B2B_pulse_count", q_t.size(), 4);
    check_pulse("B2B_H_hi", 0, a, 2, 4, 1);
    check_pulse("B2B_H_lo", 1, a, 10, 8, 1);
    check_pulse("B2B_O_hi", 2, a, 23, 4, 1);
    check_pulse("B2B_O_lo", 3, a, 31, 15, 1);

    // Reset while E is high
    @(negedge Clock);
    bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h48;
    @(negedge Clock);
    bus.iValid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge Clock);
      if (bus.oLCD_E === 1'b1) ok = 1'b1;
    end
    chk("MID_e_high", 32'(bus.oLCD_E), 1);
    Reset = 1'b1;
    @(negedge Clock);
    chk("MID_e_cleared",    32'(bus.oLCD_E), 0);
    chk("MID_rs_cleared",   32'(bus.oLCD_RS), 0);
    chk("MID_data_cleared", 32'(bus.oLCD_Data), 0);
    chk("MID_ready_low",    32'(bus.oReady), 0);
    @(negedge Clock);
    Reset = 1'b0;
    base  = cyc;
    clear_log();
    check_init("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
